if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 173 +++++++++++++++++
 tb/tb_if_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetches into a registered ID slot, handling stall, flush and delayed branches.
// Optional macro IF_PC_ALIGN_CHECK_EN adds o_exc_adel, raised on a misaligned fetch address.
module if_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target,
  output logic        o_rom_en,
  output logic [31:0] o_rom_addr,
  input  logic        i_rom_ready,
  input  logic [31:0] i_rom_data,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid,
  output logic        o_stall_req,
`ifdef IF_PC_ALIGN_CHECK_EN
  output logic        o_exc_adel,
`endif
  output logic [1:0]  o_state
);
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_HOLD   = 2'd2;
  localparam logic [1:0]  S_KILL   = 2'd3;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_br_pend;
  logic [31:0] r_br_tgt;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
`ifdef IF_PC_ALIGN_CHECK_EN
  logic        r_exc_adel;
`endif

  logic        w_br_new;
  logic        w_misalign;
  logic [31:0] w_next_pc;

  // A branch resolved in the same cycle as the delay-slot hand-off is bypassed straight into next_pc.
  assign w_br_new  = i_branch_flag & ~i_stall;
  assign w_next_pc = w_br_new  ? i_branch_target :
                     r_br_pend ? r_br_tgt        : r_req_addr + 32'd4;

`ifdef IF_PC_ALIGN_CHECK_EN
  assign w_misalign = (r_req_addr[1:0] != 2'b00);
  assign o_rom_addr = r_req_addr;
  assign o_exc_adel = r_exc_adel;
`else
  assign w_misalign = 1'b0;
  assign o_rom_addr = {r_req_addr[31:2], 2'b00};
`endif

  assign o_rom_en    = (r_state == S_KILL) | ((r_state == S_WAIT) & ~w_misalign);
  assign o_stall_req = o_rom_en & ~i_rom_ready;
  assign o_id_pc     = r_id_pc;
  assign o_id_inst   = r_id_inst;
  assign o_id_valid  = r_id_valid;
  assign o_state     = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_br_pend   <= 1'b0;
      r_br_tgt    <= 32'd0;
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
      r_id_pc     <= 32'd0;
      r_id_inst   <= 32'd0;
      r_id_valid  <= 1'b0;
`ifdef IF_PC_ALIGN_CHECK_EN
      r_exc_adel  <= 1'b0;
`endif
    end else if (i_flush) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= 32'd0;
      r_id_pc    <= 32'd0;
      r_pc       <= i_flush_pc;
      r_br_pend  <= 1'b0;
`ifdef IF_PC_ALIGN_CHECK_EN
      r_exc_adel <= 1'b0;
`endif
      // An outstanding request must drain in KILL before the redirect address can be issued.
      case (r_state)
        S_KILL: begin
          if (i_rom_ready) begin
            r_req_addr <= i_flush_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_rom_ready || w_misalign) begin
            r_req_addr <= i_flush_pc;
            r_state    <= S_WAIT;
          end else begin
            r_state <= S_KILL;
          end
        end
        default: begin
          r_req_addr <= i_flush_pc;
          r_state    <= S_WAIT;
        end
      endcase
    end else begin
      if (w_br_new) begin
        r_br_pend <= 1'b1;
        r_br_tgt  <= i_branch_target;
      end
      case (r_state)
        S_IDLE: begin
          r_req_addr <= r_pc;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
`ifdef IF_PC_ALIGN_CHECK_EN
          if (w_misalign) begin
            if (!i_stall) begin
              r_id_valid <= 1'b1;
              r_id_inst  <= 32'd0;
              r_id_pc    <= r_req_addr;
              r_exc_adel <= 1'b1;
            end
          end else
`endif
          if (i_rom_ready) begin
            if (i_stall) begin
              r_hold_inst <= i_rom_data;
              r_hold_pc   <= r_req_addr;
              r_state     <= S_HOLD;
            end else begin
              r_id_inst  <= i_rom_data;
              r_id_pc    <= r_req_addr;
              r_id_valid <= 1'b1;
              r_pc       <= w_next_pc;
              r_req_addr <= w_next_pc;
              r_br_pend  <= 1'b0;
            end
          end else if (!i_stall) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= 32'd0;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_id_inst  <= r_hold_inst;
            r_id_pc    <= r_hold_pc;
            r_id_valid <= 1'b1;
            r_pc       <= w_next_pc;
            r_req_addr <= w_next_pc;
            r_br_pend  <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        default: begin
          if (i_rom_ready) begin
            r_req_addr <= r_pc;
            r_state    <= S_WAIT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, randomized traffic against an instruction-stream model,
// plus reset and (with IF_PC_ALIGN_CHECK_EN) misaligned-fetch scenarios.
module tb_if_stage;
  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic        i_branch_flag;
  logic [31:0] i_branch_target;
  logic        o_rom_en;
  logic [31:0] o_rom_addr;
  logic        i_rom_ready;
  logic [31:0] i_rom_data;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        o_id_valid;
  logic        o_stall_req;
  logic [1:0]  o_state;
`ifdef IF_PC_ALIGN_CHECK_EN
  logic        o_exc_adel;
`endif

  if_stage dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_flush_pc      (i_flush_pc),
    .i_branch_flag   (i_branch_flag),
    .i_branch_target (i_branch_target),
    .o_rom_en        (o_rom_en),
    .o_rom_addr      (o_rom_addr),
    .i_rom_ready     (i_rom_ready),
    .i_rom_data      (i_rom_data),
    .o_id_pc         (o_id_pc),
    .o_id_inst       (o_id_inst),
    .o_id_valid      (o_id_valid),
    .o_stall_req     (o_stall_req),
`ifdef IF_PC_ALIGN_CHECK_EN
    .o_exc_adel      (o_exc_adel),
`endif
    .o_state         (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // instruction-stream model: next expected fetch PC and pending branch
  logic [31:0] m_exp_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  int          m_deliv;

  // protocol tracking and pre-edge samples
  logic        s_hold_addr;
  logic [31:0] s_addr;
  logic        c_en;
  logic [31:0] c_addr;
  logic        c_sreq;

  typedef struct packed {
    logic        st;
    logic        fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_sreq;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] fpc,
                              input logic br, input logic [31:0] bt, input logic rdy,
                              input logic e_en, input logic [31:0] e_addr, input logic e_sreq,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.st = st; v.fl = fl; v.fpc = fpc; v.br = br; v.bt = bt; v.rdy = rdy;
    v.e_en = e_en; v.e_addr = e_addr; v.e_sreq = e_sreq; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    i_rom_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("rst_rom_en", {31'd0, o_rom_en}, 32'd0);
    check("rst_rom_addr", o_rom_addr, 32'hBFC0_0000);
    check("rst_id_pc", o_id_pc, 32'd0);
    check("rst_id_inst", o_id_inst, 32'd0);
    check("rst_id_valid", {31'd0, o_id_valid}, 32'd0);
    check("rst_stall_req", {31'd0, o_stall_req}, 32'd0);
`ifdef IF_PC_ALIGN_CHECK_EN
    check("rst_exc_adel", {31'd0, o_exc_adel}, 32'd0);
`endif
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    m_exp_pc = 32'hBFC0_0000;
    m_pend = 1'b0;
    m_tgt = 32'd0;
    s_hold_addr = 1'b0;
  endtask

  // driver + scoreboard for one clock cycle
  task automatic cycle(input logic st, input logic fl, input logic [31:0] fpc,
                       input logic br, input logic [31:0] bt, input logic rdy);
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    logic        p_valid;
    logic        take;
    logic [31:0] tgt;
    i_stall = st; i_flush = fl; i_flush_pc = fpc;
    i_branch_flag = br; i_branch_target = bt; i_rom_ready = rdy;
    #1;
    i_rom_data = rdy ? mem_word(o_rom_addr) : $urandom();
    #1;
    c_en = o_rom_en; c_addr = o_rom_addr; c_sreq = o_stall_req;
    check("rom_addr_align", {30'd0, o_rom_addr[1:0]}, 32'd0);
    if (s_hold_addr) check("rom_addr_stable", o_rom_addr, s_addr);
    s_hold_addr = o_rom_en & ~rdy;
    s_addr = o_rom_addr;
    p_pc = o_id_pc; p_inst = o_id_inst; p_valid = o_id_valid;
    @(posedge i_clk);
    #1;
`ifdef IF_PC_ALIGN_CHECK_EN
    check("exc_adel_quiet", {31'd0, o_exc_adel}, 32'd0);
`endif
    if (fl) begin
      check("flush_valid", {31'd0, o_id_valid}, 32'd0);
      check("flush_inst", o_id_inst, 32'd0);
      check("flush_pc", o_id_pc, 32'd0);
      m_exp_pc = fpc;
      m_pend = 1'b0;
    end else if (st) begin
      check("stall_valid", {31'd0, o_id_valid}, {31'd0, p_valid});
      check("stall_pc", o_id_pc, p_pc);
      check("stall_inst", o_id_inst, p_inst);
    end else begin
      take = br | m_pend;
      tgt = br ? bt : m_tgt;
      if (o_id_valid) begin
        check("deliver_pc", o_id_pc, m_exp_pc);
        check("deliver_inst", o_id_inst, mem_word(m_exp_pc));
        m_deliv++;
        m_exp_pc = take ? tgt : m_exp_pc + 32'd4;
        m_pend = 1'b0;
      end else begin
        check("bubble_inst", o_id_inst, 32'd0);
        if (br) begin
          m_pend = 1'b1;
          m_tgt = bt;
        end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_stall = 1'b0; i_flush = 1'b0; i_flush_pc = 32'd0;
    i_branch_flag = 1'b0; i_branch_target = 32'd0;
    i_rom_ready = 1'b0; i_rom_data = 32'd0;
    m_deliv = 0;
    s_addr = 32'd0;
    #1;
    apply_reset();

    //                st    fl    fpc           br    bt            rdy   en    addr          sreq  valid pc
    vecs[0]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b0, 32'hBFC00000, 1'b0, 1'b0, 32'd0);
    vecs[1]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'hBFC00000, 1'b0, 1'b1, 32'hBFC00000);
    vecs[2]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'hBFC00004, 1'b0, 1'b1, 32'hBFC00004);
    vecs[3]  = mk(1'b0, 1'b0, 32'd0,        1'b1, 32'h80000100, 1'b1, 1'b1, 32'hBFC00008, 1'b0, 1'b1, 32'hBFC00008);
    vecs[4]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 32'h80000100, 1'b1, 1'b0, 32'd0);
    vecs[5]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 32'h80000100, 1'b1, 1'b0, 32'd0);
    vecs[6]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 32'h80000100, 1'b1, 1'b0, 32'd0);
    vecs[7]  = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h80000100, 1'b0, 1'b1, 32'h80000100);
    vecs[8]  = mk(1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h80000104, 1'b0, 1'b1, 32'h80000100);
    vecs[9]  = mk(1'b1, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 32'h80000104, 1'b0, 1'b1, 32'h80000100);
    vecs[10] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b0, 32'h80000104, 1'b0, 1'b1, 32'h80000104);
    vecs[11] = mk(1'b0, 1'b1, 32'h80000180, 1'b0, 32'd0,        1'b0, 1'b1, 32'h80000108, 1'b1, 1'b0, 32'd0);
    vecs[12] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 32'h80000108, 1'b1, 1'b0, 32'd0);
    vecs[13] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h80000108, 1'b0, 1'b0, 32'd0);
    vecs[14] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h80000180, 1'b0, 1'b1, 32'h80000180);
    vecs[15] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h80000184, 1'b0, 1'b1, 32'h80000184);
    vecs[16] = mk(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'd0,        1'b1, 1'b1, 32'h80000188, 1'b0, 1'b0, 32'd0);
    vecs[17] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFFFFFFFC);
    vecs[18] = mk(1'b0, 1'b0, 32'd0,        1'b0, 32'd0,        1'b1, 1'b1, 32'h00000000, 1'b0, 1'b1, 32'h00000000);

    for (int k = 0; k < 19; k++) begin
      cycle(vecs[k].st, vecs[k].fl, vecs[k].fpc, vecs[k].br, vecs[k].bt, vecs[k].rdy);
      check($sformatf("vec%0d_rom_en", k), {31'd0, c_en}, {31'd0, vecs[k].e_en});
      check($sformatf("vec%0d_rom_addr", k), c_addr, vecs[k].e_addr);
      check($sformatf("vec%0d_stall_req", k), {31'd0, c_sreq}, {31'd0, vecs[k].e_sreq});
      check($sformatf("vec%0d_id_valid", k), {31'd0, o_id_valid}, {31'd0, vecs[k].e_valid});
      if (vecs[k].e_valid) begin
        check($sformatf("vec%0d_id_pc", k), o_id_pc, vecs[k].e_pc);
        check($sformatf("vec%0d_id_inst", k), o_id_inst, mem_word(vecs[k].e_pc));
      end
    end

    m_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rf;
      logic [31:0] rb;
      if (i == 1500) begin
        apply_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        check("idle_ignores_ready_en", {31'd0, c_en}, 32'd0);
        check("idle_ignores_ready_valid", {31'd0, o_id_valid}, 32'd0);
      end
      rf = $urandom();
      rf[1:0] = 2'b00;
      rb = $urandom();
      rb[1:0] = 2'b00;
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), rf,
            ($urandom_range(0, 11) == 0), rb, ($urandom_range(0, 4) < 3));
    end
    check("progress", {31'd0, (m_deliv >= 300)}, 32'd1);

`ifdef IF_PC_ALIGN_CHECK_EN
    apply_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h80000002, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    i_stall = 1'b0; i_flush = 1'b0; i_branch_flag = 1'b0; i_rom_ready = 1'b0;
    #2;
    check("adel_rom_en", {31'd0, o_rom_en}, 32'd0);
    @(posedge i_clk);
    #1;
    check("adel_exc", {31'd0, o_exc_adel}, 32'd1);
    check("adel_valid", {31'd0, o_id_valid}, 32'd1);
    check("adel_pc", o_id_pc, 32'h80000002);
    check("adel_inst", o_id_inst, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
